// File: rtl/fnd_pkg.sv
// Shared 7-segment constants and BCD decoder for the display path.
// Segment order is {a,b,c,d,e,f,g}, a = MSB, 1 = lit.
package fnd_pkg;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1110011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // 0..9 decimal glyphs, A is a dash, B..F are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_DASH;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fnd_seg_mux.sv
// Selects the active digit's BCD/dp/blink bit and produces active-high segments,
// with leading-zero blanking and blink gating applied.
module fnd_seg_mux #(
    parameter int unsigned NUM_DIG = 6,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [4*NUM_DIG-1:0] digits_i,
    input  logic [NUM_DIG-1:0]   dp_i,
    input  logic [NUM_DIG-1:0]   blink_mask_i,
    input  logic                 blank_lz_i,
    input  logic [IDX_W-1:0]     dig_idx_i,
    input  logic                 blink_ph_i,
    output logic [6:0]           seg_o,
    output logic                 dp_o
);
    import fnd_pkg::*;

    logic [NUM_DIG-1:0] zero_up;  // digit k and every digit above it are zero
    logic [3:0]         bcd_sel;
    logic               dp_sel;
    logic               mask_sel;
    logic               lz_sel;

    // Running "all zero from here upward" chain, top digit first.
    always_comb begin
        zero_up = '0;
        zero_up[NUM_DIG-1] = (digits_i[4*NUM_DIG-1 -: 4] == 4'h0);
        for (int k = int'(NUM_DIG) - 2; k >= 0; k--) begin
            zero_up[k] = zero_up[k+1] && (digits_i[4*k +: 4] == 4'h0);
        end
    end

    // Pick the fields belonging to the digit being scanned.
    always_comb begin
        bcd_sel  = 4'h0;
        dp_sel   = 1'b0;
        mask_sel = 1'b0;
        lz_sel   = 1'b0;
        for (int k = 0; k < int'(NUM_DIG); k++) begin
            if (dig_idx_i == IDX_W'(k)) begin
                bcd_sel  = digits_i[4*k +: 4];
                dp_sel   = dp_i[k];
                mask_sel = blink_mask_i[k];
                lz_sel   = (k != 0) && zero_up[k];  // rightmost digit always shows
            end
        end
    end

    // Decode, then blank: LZ kills segments only, blink kills segments and dp.
    always_comb begin
        seg_o = seg_decode(bcd_sel);
        dp_o  = dp_sel;
        if (blank_lz_i && lz_sel) begin
            seg_o = SEG_OFF;
        end
        if (blink_ph_i && mask_sel) begin
            seg_o = SEG_OFF;
            dp_o  = 1'b0;
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// N-digit multiplexed 7-segment scan driver: clock-enable prescaler, digit index,
// blink counters and registered, polarity-adjusted pin outputs.
module fnd_scan_ctrl #(
    parameter int unsigned NUM_DIG        = 6,
    parameter int unsigned SCAN_DIV       = 5000,
    parameter int unsigned DEAD_CYC       = 1,
    parameter int unsigned BLINK_DIV      = 50,
    parameter int unsigned ENB_ACTIVE_LOW = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [4*NUM_DIG-1:0] i_digits,
    input  logic [NUM_DIG-1:0]   i_dp,
    input  logic [NUM_DIG-1:0]   i_blink_mask,
    input  logic                 i_blank_lz,
    output logic [6:0]           o_seg,
    output logic                 o_seg_dp,
    output logic [NUM_DIG-1:0]   o_seg_enb,
    output logic                 o_frame
);
    import fnd_pkg::*;

    localparam int unsigned IdxW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int unsigned PreW = $clog2(SCAN_DIV);
    localparam int unsigned BlkW = $clog2(BLINK_DIV + 1);

    localparam logic [PreW-1:0] PreMax  = PreW'(SCAN_DIV - 1);
    localparam logic [PreW-1:0] DeadCyc = PreW'(DEAD_CYC);
    localparam logic [IdxW-1:0] IdxMax  = IdxW'(NUM_DIG - 1);
    localparam logic [BlkW-1:0] BlkMax  = BlkW'(BLINK_DIV - 1);

    localparam logic [6:0]         SegIdle = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic               DpIdle  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIG-1:0] EnbIdle = (ENB_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PreW-1:0]    pre_cnt_q, pre_cnt_d;
    logic [IdxW-1:0]    dig_idx_q, dig_idx_d;
    logic [BlkW-1:0]    blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [NUM_DIG-1:0] enb_q, enb_d;
    logic               frame_q, frame_d;

    logic               tick;
    logic               last_dig;
    logic [6:0]         mux_seg;
    logic               mux_dp;
    logic [NUM_DIG-1:0] enb_act;

    assign tick     = (pre_cnt_q == PreMax);
    assign last_dig = (dig_idx_q == IdxMax);

    fnd_seg_mux #(
        .NUM_DIG (NUM_DIG),
        .IDX_W   (IdxW)
    ) u_seg_mux (
        .digits_i     (i_digits),
        .dp_i         (i_dp),
        .blink_mask_i (i_blink_mask),
        .blank_lz_i   (i_blank_lz),
        .dig_idx_i    (dig_idx_q),
        .blink_ph_i   (blink_ph_q),
        .seg_o        (mux_seg),
        .dp_o         (mux_dp)
    );

    // Prescaler, digit index and blink counters; i_en low parks them at reset values.
    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        dig_idx_d   = dig_idx_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        frame_d     = 1'b0;
        if (!i_en) begin
            pre_cnt_d   = '0;
            dig_idx_d   = '0;
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (tick) begin
            pre_cnt_d = '0;
            dig_idx_d = last_dig ? '0 : dig_idx_q + 1'b1;
            if (last_dig) begin
                frame_d = 1'b1;
                if (blink_cnt_q == BlkMax) begin
                    blink_cnt_d = '0;
                    blink_ph_d  = ~blink_ph_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    // One-hot enable for the current slot, held off during the leading dead time.
    always_comb begin
        enb_act = '0;
        for (int k = 0; k < int'(NUM_DIG); k++) begin
            enb_act[k] = (pre_cnt_q >= DeadCyc) && (dig_idx_q == IdxW'(k));
        end
    end

    // Output register inputs with pin polarity applied last.
    always_comb begin
        seg_d = SegIdle;
        dp_d  = DpIdle;
        enb_d = EnbIdle;
        if (i_en) begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~mux_seg : mux_seg;
            dp_d  = (SEG_ACTIVE_LOW != 0) ? ~mux_dp : mux_dp;
            enb_d = (ENB_ACTIVE_LOW != 0) ? ~enb_act : enb_act;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q   <= '0;
            dig_idx_q   <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            seg_q       <= SegIdle;
            dp_q        <= DpIdle;
            enb_q       <= EnbIdle;
            frame_q     <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            dig_idx_q   <= dig_idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            enb_q       <= enb_d;
            frame_q     <= frame_d;
        end
    end

    assign o_seg     = seg_q;
    assign o_seg_dp  = dp_q;
    assign o_seg_enb = enb_q;
    assign o_frame   = frame_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: 4 digits, 4-cycle slots, 1 dead cycle, blink every 2 frames.
module tb_fnd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic [15:0] i_digits;
    logic [3:0]  i_dp;
    logic [3:0]  i_blink_mask;
    logic        i_blank_lz;
    logic [6:0]  o_seg;
    logic        o_seg_dp;
    logic [3:0]  o_seg_enb;
    logic        o_frame;

    typedef struct {
        int         stamp;
        string      tag;
        logic [3:0] enb;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    exp_t  sb[$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;
    int    st     = 0;  // scan state index the next registered output is built from
    string tag    = "reset";

    fnd_scan_ctrl #(
        .NUM_DIG        (4),
        .SCAN_DIV       (4),
        .DEAD_CYC       (1),
        .BLINK_DIV      (2),
        .ENB_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (i_en),
        .i_digits     (i_digits),
        .i_dp         (i_dp),
        .i_blink_mask (i_blink_mask),
        .i_blank_lz   (i_blank_lz),
        .o_seg        (o_seg),
        .o_seg_dp     (o_seg_dp),
        .o_seg_enb    (o_seg_enb),
        .o_frame      (o_frame)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1110011;
            4'hA: return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic exp_t dark();
        exp_t e;
        e.stamp = 0;
        e.tag   = "";
        e.enb   = 4'b1111;
        e.seg   = 7'b0000000;
        e.dp    = 1'b0;
        e.frame = 1'b0;
        return e;
    endfunction

    // Expected pins for scan state s: slot = s/4, dead cycle when s%4==0,
    // 16 states per frame, blink phase flips every 2 frames.
    function automatic exp_t model(input int s, input logic [15:0] d, input logic [3:0] dp,
                                   input logic [3:0] m, input logic lz);
        exp_t e;
        int   pre;
        int   dig;
        logic blank;
        logic ph;
        pre     = s % 4;
        dig     = (s / 4) % 4;
        ph      = (((s / 16) / 2) % 2) == 1;
        e       = dark();
        e.enb   = (pre >= 1) ? ~(4'b0001 << dig) : 4'b1111;
        e.seg   = glyph(d[dig*4 +: 4]);
        e.dp    = dp[dig];
        e.frame = (s % 16) == 15;
        blank   = 1'b0;
        if (lz && dig >= 1) begin
            blank = 1'b1;
            for (int j = dig; j < 4; j++) begin
                if (d[j*4 +: 4] != 4'h0) blank = 1'b0;
            end
        end
        if (blank) e.seg = 7'b0000000;
        if (ph && m[dig]) begin
            e.seg = 7'b0000000;
            e.dp  = 1'b0;
        end
        return e;
    endfunction

    // Advance one clock and queue the expected pins for the cycle that follows the edge.
    task automatic step(input bit rst_now);
        logic        en_s;
        logic        rst_s;
        logic [15:0] d_s;
        logic [3:0]  dp_s;
        logic [3:0]  m_s;
        logic        lz_s;
        exp_t        e;
        en_s  = i_en;
        rst_s = rst;
        d_s   = i_digits;
        dp_s  = i_dp;
        m_s   = i_blink_mask;
        lz_s  = i_blank_lz;
        @(posedge clk);
        #1;
        if (rst_now) rst = 1'b1;
        if (rst_s || rst_now || !en_s) begin
            e  = dark();
            st = 0;
        end else begin
            e  = model(st, d_s, dp_s, m_s, lz_s);
            st = st + 1;
        end
        e.stamp = cyc;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // Monitor: compare every queued expectation due by this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            e = sb.pop_front();
            checks = checks + 1;
            if (e.stamp != cyc || o_seg_enb !== e.enb || o_seg !== e.seg ||
                o_seg_dp !== e.dp || o_frame !== e.frame) begin
                errors = errors + 1;
                $display("FAIL %s cyc=%0d (due %0d): got enb=%b seg=%b dp=%b frame=%b, want enb=%b seg=%b dp=%b frame=%b",
                         e.tag, cyc, e.stamp, o_seg_enb, o_seg, o_seg_dp, o_frame,
                         e.enb, e.seg, e.dp, e.frame);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        i_en         = 1'b1;
        i_digits     = 16'h1234;
        i_dp         = 4'b0000;
        i_blink_mask = 4'b0000;
        i_blank_lz   = 1'b0;

        // 1/2: dark while in reset, then scan 1234 over 2.5 frames with frame pulses.
        tag = "reset";
        run(3);
        rst = 1'b0;
        tag = "scan_1234";
        run(40);

        // 3: leading-zero blanking with dp on a blanked digit, then blanking off.
        i_digits   = 16'h0050;
        i_blank_lz = 1'b1;
        i_dp       = 4'b0100;
        tag        = "lz_on";
        run(16);
        i_blank_lz = 1'b0;
        tag        = "lz_off";
        run(16);

        // 4: blink digits 0 and 1 across several blink phases.
        i_digits     = 16'h1234;
        i_dp         = 4'b0000;
        i_blink_mask = 4'b0011;
        tag          = "blink";
        run(80);
        i_blink_mask = 4'b0000;

        // 5: dash and undefined code.
        i_digits = 16'h1CA9;
        tag      = "dash_off";
        run(16);

        // 6a: drop enable mid-slot of digit 2, then resume from digit 0.
        i_digits = 16'h1234;
        tag      = "en_pre";
        while ((st % 16) != 10) step(1'b0);
        i_en = 1'b0;
        tag  = "en_drop";
        run(2);
        i_en = 1'b1;
        tag  = "en_resume";
        run(10);

        // 6b: async reset mid-slot of digit 1, then resume from digit 0.
        tag = "rst_pre";
        while ((st % 16) != 6) step(1'b0);
        tag = "rst_async";
        step(1'b1);
        run(2);
        rst = 1'b0;
        tag = "rst_resume";
        run(10);

        repeat (2) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
